// File: rtl/rom_arb_pkg.sv
// ----------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and helpers for the ROM port arbiter.
//   MaxIdxWidth : width reserved for a requester index inside a response tag
//   idxWidth()  : bits needed to index NumReq requesters (never below 1)
//   resp_tag_t  : {valid, idx} tag carried alongside each outstanding ROM read
// ----------------------------------------------------------------------------
package rom_arb_pkg;

    // Tags are sized for the largest supported configuration so the type can
    // live in the package; the top narrows/widens indices explicitly.
    localparam int unsigned MaxIdxWidth = 8;

    function automatic int unsigned idxWidth(input int unsigned numReq);
        return (numReq <= 2) ? 1 : $clog2(numReq);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [MaxIdxWidth-1:0] idx;
    } resp_tag_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// rom_port_arbiter_if
// Requester-side bus of the ROM port arbiter.
//   req    : per-requester request            (master -> slave)
//   addr   : per-requester address            (master -> slave)
//   gnt    : grant, one-hot or zero           (slave -> master)
//   rvalid : response valid, one-hot or zero  (slave -> master)
//   rdata  : response data shared by everyone (slave -> master)
// The requesters use the master modport, the arbiter uses the slave modport.
// ----------------------------------------------------------------------------
interface rom_port_arbiter_if #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = 32
);
    logic [NumReq-1:0]                req;
    logic [NumReq-1:0][AddrWidth-1:0] addr;
    logic [NumReq-1:0]                gnt;
    logic [NumReq-1:0]                rvalid;
    logic [DataWidth-1:0]             rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/rom_arb_resp_pipe.sv
// ----------------------------------------------------------------------------
// rom_arb_resp_pipe
// Latency-deep shift register of response tags. Each cycle the tag of the
// read issued this cycle enters stage 0 and the oldest tag leaves, so the
// output tag lines up with the ROM data for that read.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all tags)
//   tag_i         : tag of the read issued this cycle
//   tag_o         : tag whose ROM data is on the data bus this cycle
// ----------------------------------------------------------------------------
module rom_arb_resp_pipe
    import rom_arb_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  resp_tag_t tag_i,
    output resp_tag_t tag_o
);

    resp_tag_t [Latency-1:0] stage_q;

    // Clearing on reset drops every in-flight read, so no stale response can
    // surface once reset is released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int s = 1; s < int'(Latency); s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign tag_o = stage_q[Latency-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// ----------------------------------------------------------------------------
// rom_port_arbiter
// Shares one fixed-latency read-only ROM port between NumReq requesters.
// One request is granted per cycle; each read response is steered back to
// its issuer through a latency-matched pipeline of grant indices.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : requester bus (slave modport): req, addr, gnt, rvalid, rdata
//   rom_req_o     : ROM read request
//   rom_addr_o    : ROM address (holds its last value while idle)
//   rom_rdata_i   : ROM data, valid Latency cycles after rom_req_o
// Build option:
//   ROM_ARB_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins
//   ROM_ARB_FIXED_PRIO_EN undefined -> round-robin (default)
// ----------------------------------------------------------------------------
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Latency   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rom_port_arbiter_if.slave    bus,
    output logic                 rom_req_o,
    output logic [AddrWidth-1:0] rom_addr_o,
    input  logic [DataWidth-1:0] rom_rdata_i
);

    localparam int unsigned IdxWidth = idxWidth(NumReq);

    logic [IdxWidth-1:0]  winner;
    logic                 anyReq;
    logic [AddrWidth-1:0] selAddr;
    logic [AddrWidth-1:0] romAddr_q;
    resp_tag_t            tagIn;
    resp_tag_t            tagOut;

    assign anyReq = |bus.req;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Scanning downward lets the lowest active index overwrite the others.
    always_comb begin
        winner = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                winner = IdxWidth'(i);
            end
        end
    end
`else
    logic [IdxWidth-1:0] rrPtr_q;
    logic [IdxWidth-1:0] rrPtr_d;

    // Search starts at the pointer and wraps modulo NumReq; the first active
    // request found wins.
    always_comb begin
        int unsigned cand;
        logic        found;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = int'(rrPtr_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = IdxWidth'(cand);
            end
        end
    end

    // The pointer moves just past the winner so it ranks lowest next time;
    // with a single requester this stays at 0.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (anyReq) begin
            rrPtr_d = (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end
`endif

    // Grant decode and address mux are written as compare loops so an index
    // beyond NumReq-1 can never select a nonexistent requester.
    always_comb begin
        bus.gnt = '0;
        selAddr = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (winner == IdxWidth'(i)) begin
                bus.gnt[i] = anyReq;
                selAddr    = bus.addr[i];
            end
        end
    end

    assign rom_req_o  = anyReq;
    assign rom_addr_o = anyReq ? selAddr : romAddr_q;

    // Remembers the last driven address so the ROM address is stable while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            romAddr_q <= '0;
        end else begin
            romAddr_q <= rom_addr_o;
        end
    end

    always_comb begin
        tagIn       = '0;
        tagIn.valid = anyReq;
        tagIn.idx   = MaxIdxWidth'(winner);
    end

    rom_arb_resp_pipe #(
        .Latency (Latency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tagIn),
        .tag_o  (tagOut)
    );

    // ROM data is passed through unmasked; only rvalid qualifies it.
    always_comb begin
        bus.rvalid = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            bus.rvalid[i] = tagOut.valid && (tagOut.idx == MaxIdxWidth'(i));
        end
    end

    assign bus.rdata = rom_rdata_i;

endmodule
